lfsr_counter_bank: RTL and testbench

//   Multi-channel Galois-LFSR event counter bank. Width and polynomial are parametrised.

---
 rtl/lfsr_counter_bank.sv | 80 ++++++++
 tb/tb_lfsr_counter_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_counter_bank.sv
// Multi-channel Galois-LFSR event counter bank.
// Each channel advances its LFSR once per cycle in which its sig bit and ch_en bit are both high.
// A common cutoff strobe closes the window: all live states go to a shadow bank, which is then
// offered to the host over a valid/ack handshake with a sequence number and a sticky overrun flag.
module lfsr_counter_bank #(
  parameter int                NUM_CH = 4,
  parameter int                WIDTH  = 32,
  parameter logic [WIDTH-1:0]  POLY   = 32'hA3000000,
  parameter logic [WIDTH-1:0]  SEED   = 32'h00000001,
  parameter int                SEQ_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       sig,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    cutoff,
  output logic [NUM_CH*WIDTH-1:0] snap_count,
  output logic                    snap_valid,
  input  logic                    snap_ack,
  output logic                    snap_overrun,
  output logic [SEQ_W-1:0]        snap_seq
);

  // One Galois shift: bit 0 falls out and, when set, folds the feedback mask into the state.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? POLY : '0);
  endfunction

  // State after one step from the reload value; used when an event lands on the cutoff cycle.
  localparam logic [WIDTH-1:0] SEED_STEP1 = (SEED >> 1) ^ (SEED[0] ? POLY : '0);

  logic [NUM_CH-1:0] hit;
  logic [WIDTH-1:0]  live [NUM_CH];
  logic              ack_ok;

  assign hit    = sig & ch_en;
  assign ack_ok = snap_ack & snap_valid;

  // Live counters: reload at cutoff (the cutoff-cycle event opens the new window), else step on hit.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (!rst_n) begin
        live[k] <= SEED;
      end else if (cutoff) begin
        live[k] <= hit[k] ? SEED_STEP1 : SEED;
      end else if (hit[k]) begin
        live[k] <= lfsr_step(live[k]);
      end
    end
  end

  // Shadow bank: capture the pre-edge live states on cutoff; held otherwise, including across ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_count <= '0;
    end else if (cutoff) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snap_count[k*WIDTH +: WIDTH] <= live[k];
      end
    end
  end

  // Handshake and sequence: a capture on top of unconsumed data raises the sticky overrun,
  // unless the host acks that data in the same cycle; a plain ack clears valid and overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_valid   <= 1'b0;
      snap_overrun <= 1'b0;
      snap_seq     <= '0;
    end else if (cutoff) begin
      snap_valid   <= 1'b1;
      snap_overrun <= snap_valid & ~snap_ack;
      snap_seq     <= snap_seq + SEQ_W'(1);
    end else if (ack_ok) begin
      snap_valid   <= 1'b0;
      snap_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_counter_bank.sv
// Bench for lfsr_counter_bank: a 32-bit/4-channel instance and a 16-bit/3-channel instance
// driven with the same stimulus. A window-level model (event counts per channel plus the
// handshake rules) predicts each cycle's valid/overrun/seq and each snapshot's contents.
module tb_lfsr_counter_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   sig;
  logic [3:0]   ch_en;
  logic         cutoff;
  logic         ack;

  logic [127:0] a_count;
  logic         a_valid, a_ovr;
  logic [7:0]   a_seq;
  logic [47:0]  b_count;
  logic         b_valid, b_ovr;
  logic [7:0]   b_seq;

  always #5 clk = ~clk;

  lfsr_counter_bank #(
    .NUM_CH(4), .WIDTH(32), .POLY(32'hA3000000), .SEED(32'h00000001), .SEQ_W(8)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .sig(sig), .ch_en(ch_en), .cutoff(cutoff),
    .snap_count(a_count), .snap_valid(a_valid), .snap_ack(ack),
    .snap_overrun(a_ovr), .snap_seq(a_seq)
  );

  lfsr_counter_bank #(
    .NUM_CH(3), .WIDTH(16), .POLY(16'hD008), .SEED(16'h0001), .SEQ_W(8)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .sig(sig[2:0]), .ch_en(ch_en[2:0]), .cutoff(cutoff),
    .snap_count(b_count), .snap_valid(b_valid), .snap_ack(ack),
    .snap_overrun(b_ovr), .snap_seq(b_seq)
  );

  typedef struct { int n [4]; int seq; } snap_t;
  typedef struct { bit v; bit o; int seq; bit zero; } st_t;

  snap_t qsnap_a[$], qsnap_b[$];
  st_t   qst_a[$],   qst_b[$];

  int tests = 0;
  int fails = 0;

  // Window-level reference state.
  int m_ev [4];
  bit m_v, m_o, m_zero;
  int m_seq;

  int dec16 [65536];
  int prev_seq [2];

  logic [31:0] oc [2][4];
  logic        ov [2], oo [2];
  logic [7:0]  os [2];

  always_comb begin
    for (int k = 0; k < 4; k++) oc[0][k] = a_count[k*32 +: 32];
    for (int k = 0; k < 3; k++) oc[1][k] = {16'h0, b_count[k*16 +: 16]};
    oc[1][3] = 32'h0;
    ov[0] = a_valid; ov[1] = b_valid;
    oo[0] = a_ovr;   oo[1] = b_ovr;
    os[0] = a_seq;   os[1] = b_seq;
  end

  function automatic logic [31:0] step32(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'hA3000000 : 32'h0);
  endfunction

  function automatic logic [15:0] step16(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hD008 : 16'h0);
  endfunction

  // State reached after n events from the seed.
  function automatic logic [31:0] nth32(input int n);
    logic [31:0] x = 32'h1;
    for (int i = 0; i < n; i++) x = step32(x);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and advance the reference model on the same edge.
  task automatic cyc(input logic [3:0] s, input logic [3:0] e, input logic c,
                     input logic a, input logic r);
    snap_t rec;
    st_t   st;
    sig = s; ch_en = e; cutoff = c; ack = a; rst_n = r;
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < 4; k++) m_ev[k] = 0;
      m_v = 0; m_o = 0; m_seq = 0; m_zero = 1;
    end else if (c) begin
      m_seq = (m_seq + 1) % 256;
      for (int k = 0; k < 4; k++) begin
        rec.n[k] = m_ev[k];
        m_ev[k]  = (s[k] & e[k]) ? 1 : 0;
      end
      rec.seq = m_seq;
      qsnap_a.push_back(rec);
      qsnap_b.push_back(rec);
      m_o = m_v & ~a;
      m_v = 1;
      m_zero = 0;
    end else begin
      if (a && m_v) begin m_v = 0; m_o = 0; end
      for (int k = 0; k < 4; k++) if (s[k] & e[k]) m_ev[k]++;
    end
    st.v = m_v; st.o = m_o; st.seq = m_seq; st.zero = m_zero;
    qst_a.push_back(st);
    qst_b.push_back(st);
    #1;
  endtask

  task automatic mon(input int d);
    st_t   st;
    snap_t rec;
    int    nch;
    string p;
    nch = (d == 0) ? 4 : 3;
    p   = (d == 0) ? "w32" : "w16";
    if (d == 0 ? qst_a.size() == 0 : qst_b.size() == 0) return;
    st = (d == 0) ? qst_a.pop_front() : qst_b.pop_front();
    chk({p, " valid"},   32'(ov[d]), 32'(st.v));
    chk({p, " overrun"}, 32'(oo[d]), 32'(st.o));
    chk({p, " seq"},     32'(os[d]), 32'(st.seq));
    if (st.zero)
      for (int k = 0; k < nch; k++) chk({p, " reset count"}, oc[d][k], 32'h0);
    if (ov[d] && int'(os[d]) != prev_seq[d]) begin
      tests++;
      if (d == 0 ? qsnap_a.size() == 0 : qsnap_b.size() == 0) begin
        fails++;
        $display("FAIL %s unexpected snapshot: got seq %0d expected none", p, os[d]);
      end else begin
        rec = (d == 0) ? qsnap_a.pop_front() : qsnap_b.pop_front();
        chk({p, " snap seq"}, 32'(os[d]), 32'(rec.seq));
        for (int k = 0; k < nch; k++) begin
          if (d == 0) chk($sformatf("w32 snap ch%0d", k), oc[0][k], nth32(rec.n[k]));
          else chk($sformatf("w16 decoded events ch%0d", k),
                   32'(dec16[oc[1][k][15:0]]), 32'(rec.n[k] % 65535));
        end
      end
    end
    prev_seq[d] = int'(os[d]);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    logic [15:0] x;
    for (int i = 0; i < 65536; i++) dec16[i] = -1;
    x = 16'h1;
    for (int i = 0; i < 65535; i++) begin
      dec16[x] = i;
      x = step16(x);
    end
    prev_seq[0] = 0; prev_seq[1] = 0;

    // Reset.
    cyc(4'h0, 4'hF, 0, 0, 0);
    cyc(4'h0, 4'hF, 0, 0, 0);
    // Three events on ch0, cutoff with sig low: expect 32'h28C00000 / seq 1.
    repeat (3) cyc(4'h1, 4'hF, 0, 0, 1);
    cyc(4'h0, 4'hF, 1, 0, 1);
    cyc(4'h0, 4'hF, 0, 0, 1);
    // Cutoff with an event opens the window at one step; no-ack second capture overruns.
    cyc(4'h1, 4'hF, 1, 0, 1);
    cyc(4'h0, 4'hF, 0, 0, 1);
    cyc(4'h0, 4'hF, 1, 0, 1);
    cyc(4'h0, 4'hF, 0, 0, 1);
    // Ack clears valid and overrun; ack while empty is ignored.
    cyc(4'h0, 4'hF, 0, 1, 1);
    cyc(4'h0, 4'hF, 0, 1, 1);
    // Capture, then cutoff together with ack: valid stays, no overrun.
    cyc(4'h3, 4'hF, 1, 0, 1);
    cyc(4'h6, 4'hF, 0, 0, 1);
    cyc(4'h0, 4'hF, 1, 1, 1);
    // Back-to-back cutoffs.
    cyc(4'hF, 4'hF, 1, 0, 1);
    cyc(4'hF, 4'hF, 1, 1, 1);
    cyc(4'h0, 4'hF, 1, 0, 1);
    cyc(4'h0, 4'hF, 0, 1, 1);
    // ch1 disabled while its sig toggles.
    for (int i = 0; i < 6; i++) cyc((i % 2) ? 4'h2 : 4'h3, 4'hD, 0, 0, 1);
    cyc(4'h0, 4'hD, 1, 0, 1);
    cyc(4'h0, 4'hF, 0, 1, 1);
    // Reset mid-window aborts the window.
    repeat (4) cyc(4'hF, 4'hF, 0, 0, 1);
    cyc(4'hF, 4'hF, 1, 0, 1);
    repeat (3) cyc(4'hF, 4'hF, 0, 0, 1);
    cyc(4'hF, 4'hF, 0, 0, 0);
    repeat (2) cyc(4'h5, 4'hF, 0, 0, 1);
    cyc(4'h0, 4'hF, 1, 0, 1);
    cyc(4'h0, 4'hF, 0, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 20000; i++) begin
      logic [3:0] s, e;
      logic c, a, r;
      s = 4'($urandom);
      e = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      c = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1999) != 0);
      cyc(s, e, c, a, r);
    end
    repeat (3) cyc(4'h0, 4'hF, 0, 0, 1);

    @(negedge clk);
    #1;
    chk("w32 snapshots outstanding", 32'(qsnap_a.size()), 32'h0);
    chk("w16 snapshots outstanding", 32'(qsnap_b.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
